// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, frame data width and
// the idle level of the serial line.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery handshake between the UART receiver and its consumer.
//   rdata  : received byte, valid while rvalid=1
//   rvalid : byte available, held until accepted
//   rready : consumer accepts; transfer on rvalid && rready at posedge clk
// master = receiver (drives rdata/rvalid), slave = consumer (drives rready).
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rdata;
  logic                      rvalid;
  logic                      rready;

  modport master (output rdata, output rvalid, input rready);
  modport slave  (input rdata, input rvalid, output rready);

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads RESET_VALUE into every stage
//   d   : asynchronous input
//   q   : d after SYNC_STAGES flops
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: oversamples RX at CLKS_PER_BIT clocks per bit, finds the
// mid-point of the start bit, samples each data bit (LSB first) and the stop
// bit one bit-time apart, and hands completed bytes out on a valid/ready port.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   RX        : asynchronous serial line, idle high
//   rx_if     : byte handshake (rdata, rvalid out; rready in)
//   busy      : receiver is not idle
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while a held byte was unread
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX,
  uart_rx_if.master        rx_if,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_idle;

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q;

  logic                      sample_bit;
  logic                      stop_good;
  logic                      stop_bad;

  uart_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (UART_IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RX),
    .q   (rx_s)
  );

  assign rx_idle = (rx_s == UART_IDLE_LEVEL);

  // Next-state logic. cnt is cleared on every state transition and held at
  // zero in the waiting states, so it never needs to saturate.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_idle) begin
          state_d = START;
        end
      end

      START: begin
        // Mid-point of the start bit: a line back at idle was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_idle ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          sample_bit = 1'b1;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          stop_good = rx_idle;
          stop_bad  = !rx_idle;
          state_d   = rx_idle ? IDLE : BREAK;
        end
      end

      BREAK: begin
        // A line held low after a bad stop bit must go idle before the next
        // start bit is recognised.
        cnt_d = '0;
        if (rx_idle) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      if (sample_bit) begin
        shift_q[bit_idx_q] <= rx_s;
      end
    end
  end

  // Output register, updated on the edge that takes the stop sample. A held
  // byte being accepted on that same edge makes room for the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_if.rdata  <= '0;
      rx_if.rvalid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_good && rx_if.rvalid && !rx_if.rready;
      if (stop_good && (!rx_if.rvalid || rx_if.rready)) begin
        rx_if.rdata  <= shift_q;
        rx_if.rvalid <= 1'b1;
      end else if (rx_if.rvalid && rx_if.rready) begin
        rx_if.rvalid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Expected bytes go into a scoreboard queue when a frame is driven and are
// compared when the consumer side sees a transfer. All stimulus and
// observation run in one process: inputs change 1 time unit after posedge,
// outputs are observed on the negedge and 1 time unit after posedge.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB     = 16;
  localparam int unsigned EXP_LAT = 154;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  logic clk;
  logic rst;
  logic RX;
  logic busy;
  logic frame_err;
  logic overrun;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rx_if     (rx_if),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned cyc;
  int unsigned n_xfer, n_ferr, n_ovr;
  int unsigned t_cap, t_rise;
  logic        rv_prev, rr_prev;
  logic [7:0]  rd_prev;
  logic [7:0]  sb_q[$];
  vec_t        vecs[6];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Consumer-side observation, called once per cycle on the negedge.
  task automatic monitor();
    logic [7:0] exp_b;
    if (rst) begin
      rv_prev = 1'b0;
      rr_prev = 1'b0;
      rd_prev = '0;
    end else begin
      if (rx_if.rvalid && !rv_prev) t_rise = cyc;
      if (rv_prev && !rr_prev) begin
        check("rvalid_hold", {31'd0, rx_if.rvalid}, 32'd1);
        check("rdata_hold", {24'd0, rx_if.rdata}, {24'd0, rd_prev});
      end
      if (rx_if.rvalid && rx_if.rready) begin
        n_xfer++;
        check("sb_pending", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          check("xfer_rdata", {24'd0, rx_if.rdata}, {24'd0, exp_b});
        end
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (frame_err || overrun) check("err_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      rv_prev = rx_if.rvalid;
      rr_prev = rx_if.rready;
      rd_prev = rx_if.rdata;
    end
  endtask

  // Advance one clock: observe on negedge, return 1 unit after the posedge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive the first nbits bits of a frame (LSB first), one bit-time each.
  // t_cap is the index of the edge that first registers the start bit.
  task automatic send_bits(input logic [9:0] frame, input int unsigned nbits);
    t_cap = cyc + 1;
    for (int unsigned i = 0; i < nbits; i++) begin
      RX = frame[i];
      repeat (CPB) cycle();
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bits({stop, data, 1'b0}, 10);
    RX = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int unsigned x0, f0, o0, cnt;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    n_xfer   = 0;
    n_ferr   = 0;
    n_ovr    = 0;
    t_cap    = 0;
    t_rise   = 0;
    RX       = 1'b1;
    rst      = 1'b1;
    rx_if.rready = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0};

    @(posedge clk);
    #1;
    cyc = 1;
    repeat (3) cycle();

    // Reset state
    check("rst_rvalid", {31'd0, rx_if.rvalid}, 32'd0);
    check("rst_rdata", {24'd0, rx_if.rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (4) cycle();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Table of single frames with the consumer always ready
    rx_if.rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x0 = n_xfer;
      f0 = n_ferr;
      o0 = n_ovr;
      t_rise = 0;
      if (vecs[i].exp_valid) sb_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (CPB) cycle();
      check($sformatf("vec%0d_xfer", i), n_xfer - x0, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, {31'd0, vecs[i].exp_ferr});
      check($sformatf("vec%0d_ovr", i), n_ovr - o0, 32'd0);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_latency", i), t_rise - t_cap, EXP_LAT);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_rvalid", i), {31'd0, rx_if.rvalid}, 32'd0);
    end

    // Back-to-back frames with no reader: second byte overruns
    rx_if.rready = 1'b0;
    x0 = n_xfer;
    o0 = n_ovr;
    sb_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) cycle();
    check("ovr_rvalid", {31'd0, rx_if.rvalid}, 32'd1);
    check("ovr_rdata", {24'd0, rx_if.rdata}, 32'h00);
    check("ovr_pulses", n_ovr - o0, 32'd1);
    check("ovr_no_xfer", n_xfer - x0, 32'd0);
    rx_if.rready = 1'b1;
    cycle();
    rx_if.rready = 1'b0;
    check("ovr_drain_rvalid", {31'd0, rx_if.rvalid}, 32'd0);
    check("ovr_drain_xfer", n_xfer - x0, 32'd1);

    // Bad stop bit, then the line held low for 40 bit-times
    x0 = n_xfer;
    f0 = n_ferr;
    send_bits({1'b0, 8'h3C, 1'b0}, 10);
    cnt = 0;
    for (int unsigned i = 0; i < 40 * CPB; i++) begin
      cycle();
      if (!busy) cnt++;
    end
    check("brk_ferr", n_ferr - f0, 32'd1);
    check("brk_idle_cycles", cnt, 32'd0);
    check("brk_rvalid", {31'd0, rx_if.rvalid}, 32'd0);
    check("brk_xfer", n_xfer - x0, 32'd0);
    RX = 1'b1;
    repeat (6) cycle();
    check("brk_exit_busy", {31'd0, busy}, 32'd0);
    check("brk_ferr_after", n_ferr - f0, 32'd1);

    // Short low glitch on the idle line
    x0 = n_xfer;
    f0 = n_ferr;
    cnt = 0;
    RX = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cycle();
      if (busy) cnt++;
    end
    RX = 1'b1;
    for (int unsigned i = 0; i < 36; i++) begin
      cycle();
      if (busy) cnt++;
    end
    check("glitch_busy_cycles", cnt, 32'd8);
    check("glitch_xfer", n_xfer - x0, 32'd0);
    check("glitch_ferr", n_ferr - f0, 32'd0);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);

    // Reset during bit 4 of 0x5A, then a clean 0xC3
    rx_if.rready = 1'b1;
    x0 = n_xfer;
    send_bits({1'b1, 8'h5A, 1'b0}, 5);
    RX = 1'b1;
    repeat (CPB / 2) cycle();
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rvalid", {31'd0, rx_if.rvalid}, 32'd0);
    repeat (2 * CPB) cycle();
    check("midrst_no_xfer", n_xfer - x0, 32'd0);
    t_rise = 0;
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (CPB) cycle();
    check("midrst_c3_xfer", n_xfer - x0, 32'd1);
    check("midrst_c3_latency", t_rise - t_cap, EXP_LAT);

    // New byte completes on the same edge the held byte is accepted
    rx_if.rready = 1'b0;
    x0 = n_xfer;
    o0 = n_ovr;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    check("sim_first_rvalid", {31'd0, rx_if.rvalid}, 32'd1);
    check("sim_first_rdata", {24'd0, rx_if.rdata}, 32'h11);
    sb_q.push_back(8'h22);
    send_bits({1'b1, 8'h22, 1'b0}, 9);
    RX = 1'b1;
    repeat (10) cycle();
    rx_if.rready = 1'b1;
    cycle();
    rx_if.rready = 1'b0;
    check("sim_rvalid", {31'd0, rx_if.rvalid}, 32'd1);
    check("sim_rdata", {24'd0, rx_if.rdata}, 32'h22);
    check("sim_overrun_now", {31'd0, overrun}, 32'd0);
    repeat (CPB) cycle();
    check("sim_ovr", n_ovr - o0, 32'd0);
    check("sim_rdata_held", {24'd0, rx_if.rdata}, 32'h22);
    rx_if.rready = 1'b1;
    cycle();
    rx_if.rready = 1'b0;
    check("sim_drain_rvalid", {31'd0, rx_if.rvalid}, 32'd0);
    check("sim_xfer", n_xfer - x0, 32'd2);

    repeat (4) cycle();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
